// File: rtl/rd_frame_packer.sv
// Read-clock frame packer: wraps FIFO bytes into SYNC / SEQ / payload / checksum frames,
// padding the payload with PAD_BYTE once the FIFO has starved for TIMEOUT cycles.
module rd_frame_packer #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      FRAME_LEN = 16,
  parameter int unsigned      TIMEOUT   = 64,
  parameter logic [WIDTH-1:0] SYNC_BYTE = 8'hA5,
  parameter logic [WIDTH-1:0] PAD_BYTE  = 8'h00
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             frame_done,
  output logic             frame_padded,
  output logic [7:0]       seq_num
);

  localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    LAST_IDX  = 8'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEQ     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CSUM    = 2'd3
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t          state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_padded_q, frame_padded_d;
  logic [7:0]      seq_num_q, seq_num_d;
  logic            pad_mode_q, pad_mode_d;
  logic [7:0]      count_q, count_d;
  logic [7:0]      csum_q, csum_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            load_s;
  logic            pop_s;

  // Next-state, output-register and FIFO pop decode
  always_comb begin
    load_s         = !out_valid_q || out_ready;
    pop_s          = !reset && load_s && (state_q == S_PAYLOAD) && !fifo_empty && !pad_mode_q;
    state_d        = state_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_last_d     = out_last_q;
    frame_padded_d = frame_padded_q;
    pad_mode_d     = pad_mode_q;
    count_d        = count_q;
    csum_d         = csum_q;
    tmo_d          = tmo_q;
    frame_done_d   = out_valid_q && out_ready && out_last_q;
    if (frame_done_d) begin
      seq_num_d = seq_num_q + 8'd1;
    end else begin
      seq_num_d = seq_num_q;
    end
    // a load with nothing to send drops valid; each loaded byte re-asserts it below
    if (load_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      S_IDLE: begin
        if (load_s && !fifo_empty) begin
          out_data_d     = SYNC_BYTE;
          out_valid_d    = 1'b1;
          frame_padded_d = 1'b0;
          state_d        = S_SEQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEQ: begin
        if (load_s) begin
          out_data_d  = seq_num_q;
          out_valid_d = 1'b1;
          count_d     = 8'd0;
          csum_d      = 8'd0;
          tmo_d       = '0;
          state_d     = S_PAYLOAD;
        end else begin
          state_d = S_SEQ;
        end
      end
      S_PAYLOAD: begin
        if (load_s && pad_mode_q) begin
          out_data_d  = PAD_BYTE;
          out_valid_d = 1'b1;
          csum_d      = csum_add(csum_q, PAD_BYTE);
          count_d     = count_q + 8'd1;
          state_d     = (count_q == LAST_IDX) ? S_CSUM : S_PAYLOAD;
        end else if (pop_s) begin
          out_data_d  = fifo_data;
          out_valid_d = 1'b1;
          csum_d      = csum_add(csum_q, fifo_data);
          count_d     = count_q + 8'd1;
          tmo_d       = '0;
          state_d     = (count_q == LAST_IDX) ? S_CSUM : S_PAYLOAD;
        end else if (load_s && fifo_empty) begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TMO_LIMIT) begin
            pad_mode_d     = 1'b1;
            frame_padded_d = 1'b1;
          end else begin
            pad_mode_d = pad_mode_q;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_CSUM: begin
        if (load_s) begin
          out_data_d  = csum_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          pad_mode_d  = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_CSUM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_padded_q <= 1'b0;
      seq_num_q      <= 8'd0;
      pad_mode_q     <= 1'b0;
      count_q        <= 8'd0;
      csum_q         <= 8'd0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      frame_done_q   <= frame_done_d;
      frame_padded_q <= frame_padded_d;
      seq_num_q      <= seq_num_d;
      pad_mode_q     <= pad_mode_d;
      count_q        <= count_d;
      csum_q         <= csum_d;
      tmo_q          <= tmo_d;
    end
  end

  assign fifo_rd_en   = pop_s;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign frame_done   = frame_done_q;
  assign frame_padded = frame_padded_q;
  assign seq_num      = seq_num_q;

endmodule
